framebuffer_bram_fill: RTL
==========================

Name: framebuffer_bram_fill

Overview:
Parametrised simple dual-port frame buffer, the successor to the 1-bit 640x480 buffer.
- Generalises resolution, bits per pixel and read latency; adds a read-valid pipeline and address range checking.
- Adds a hardware fill engine that sweeps the whole buffer to a constant colour without CPU involvement.
- Sits between the character/background renderer (write side) and the VGA timing/output stage (read side).

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines; DEPTH = H_RES*V_RES (localparam)
PIX_W, 1, bits per pixel
ADDR_W, 19, address width; elaboration error if 2**ADDR_W < DEPTH
RD_LAT, 1, read latency in cycles, legal values 1 or 2 (2 adds an output register); elaboration error otherwise

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
we  in  1  host write enable
waddr  in  ADDR_W  host write address (linear, y*H_RES+x)
wdata  in  PIX_W  host write data
wr_drop  out  1  1-cycle pulse: host write discarded (fill busy or address out of range)
fill_start  in  1  request full-buffer fill
fill_value  in  PIX_W  fill colour, sampled with fill_start
fill_busy  out  1  fill engine active
fill_done  out  1  1-cycle pulse when fill completes
re  in  1  read enable
raddr  in  ADDR_W  read address
rdata  out  PIX_W  read data
rvalid  out  1  rdata valid for the read issued RD_LAT cycles earlier

Behaviour:
- Reset: fill_busy=0, fill_done=0, wr_drop=0, rvalid=0, rdata=0, FSM=IDLE. Memory contents are not reset. Mem declared ram_style "block".
- Host write (FSM IDLE, we=1, waddr<DEPTH): mem[waddr]<=wdata at the edge.
  - we=1 with waddr>=DEPTH: no write; wr_drop=1 next cycle.
  - we=1 while fill_busy=1: no write; wr_drop=1 next cycle.
- Fill FSM states:
  - IDLE -> FILL on fill_start=1. Latches fill_value; fill counter=0.
  - FILL: each cycle writes mem[cnt]<=latched value, then cnt++. fill_busy=1 for exactly DEPTH cycles, starting the cycle after fill_start.
  - After the write to DEPTH-1 -> IDLE. In that next cycle fill_done=1 and fill_busy=0.
  - fill_start while busy: ignored, no restart.
  - fill_start and we in the same IDLE cycle: the host write commits; the fill then overwrites it.
- Reset mid-fill: FSM returns to IDLE at once. Buffer stays partially filled. No fill_done pulse.
- Read port is independent of the fill. Reads during a fill return old or new data per address; no read/write collision hazard is defined beyond this.
  - Same-address read and write in one cycle: read returns the old data (read-first).
- Read timing:
  - re=1 at edge t. RD_LAT=1: rdata/rvalid update at t+1. RD_LAT=2: at t+2.
  - re=0: rvalid=0 that slot and rdata holds its previous value.
  - raddr>=DEPTH with re=1: rvalid=1, rdata=0.
- Counter width ADDR_W. The counter never wraps: termination compares against DEPTH-1.

Test Plan:
(H_RES=8, V_RES=4 => DEPTH=32, PIX_W=4, unless noted)
1. Write mem[5]=0xA; read raddr=5 with re=1 -> RD_LAT=1: rdata=0xA, rvalid=1 one cycle later; RD_LAT=2: two cycles later.
2. fill_start with fill_value=0x3 at cycle 0 -> fill_busy=1 cycles 1..32, fill_done pulse at cycle 33. Reading all 32 addresses afterwards returns 0x3.
3. we=1 to addr 7 during a fill -> wr_drop=1 next cycle; after fill_done, addr 7 reads the fill value. waddr=40 in IDLE -> wr_drop=1, no memory change.
4. Assert rst at fill cycle 10 -> fill_busy=0 next cycle, no fill_done; addrs 0..9 hold the fill value, addr 20 holds its prior value 0x6.
5. Same-cycle write 0x9 and read at addr 3 (old value 0x1) -> rdata=0x1; the next read returns 0x9. raddr=33 -> rdata=0, rvalid=1.
6. fill_start re-asserted at fill cycle 5 -> ignored; exactly one fill_done, at cycle 33.

Source files
------------

// File: rtl/framebuffer_bram_fill.sv
// -----------------------------------------------------------------------------
// framebuffer_bram_fill
//
// Parametrised simple dual-port frame buffer with a hardware fill engine.
// The write side is shared between the host (renderer) and the fill engine;
// the read side feeds the display stage and is fully independent of both.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (memory contents are kept)
//   we/waddr/wdata  host write; dropped (wr_drop pulse) while filling or
//                   when waddr is outside the frame
//   wr_drop     1-cycle pulse: the previous cycle's host write was discarded
//   fill_start  start a full-buffer fill with fill_value (ignored when busy)
//   fill_busy   fill engine sweeping the buffer
//   fill_done   1-cycle pulse after the last pixel has been written
//   re/raddr    read request; out-of-frame addresses return zero
//   rdata       read data, RD_LAT cycles after the request
//   rvalid      rdata corresponds to a request issued RD_LAT cycles earlier
// -----------------------------------------------------------------------------
module framebuffer_bram_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int PIX_W  = 1,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  output logic              wr_drop,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata,
  output logic              rvalid
);

  localparam int DEPTH = H_RES * V_RES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  if ((64'(1) << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("framebuffer_bram_fill: ADDR_W too small for H_RES*V_RES");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("framebuffer_bram_fill: RD_LAT must be 1 or 2");
  end

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [PIX_W-1:0]   fill_val_q, fill_val_d;
  logic               fill_done_q, fill_done_d;
  logic               wr_drop_q, wr_drop_d;

  logic               waddr_ok, raddr_ok;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_addr;
  logic [PIX_W-1:0]   mem_wdata;

  assign waddr_ok = {1'b0, waddr} < DEPTH_X;
  assign raddr_ok = {1'b0, raddr} < DEPTH_X;

  // Fill FSM and write-port arbitration: the fill engine owns the write port
  // for the whole sweep; host writes are only accepted while idle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_val_d  = fill_val_q;
    mem_we      = 1'b0;
    mem_addr    = waddr[IDX_W-1:0];
    mem_wdata   = wdata;
    fill_done_d = 1'b0;
    wr_drop_d   = we && ((state_q == S_FILL) || !waddr_ok);

    unique case (state_q)
      S_IDLE: begin
        // A host write in the same cycle as fill_start still commits; the
        // sweep overwrites it later.
        mem_we = we && waddr_ok;
        if (fill_start) begin
          state_d    = S_FILL;
          cnt_d      = '0;
          fill_val_d = fill_value;
        end
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q[IDX_W-1:0];
        mem_wdata = fill_val_q;
        // Terminate on the last pixel instead of letting the counter wrap.
        if (cnt_q == LAST) begin
          state_d     = S_IDLE;
          fill_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fill_val_q  <= '0;
      fill_done_q <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_val_q  <= fill_val_d;
      fill_done_q <= fill_done_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  assign fill_busy = (state_q == S_FILL);
  assign fill_done = fill_done_q;
  assign wr_drop   = wr_drop_q;

  // Frame storage.
  (* ram_style = "block" *) logic [PIX_W-1:0] mem [DEPTH];

  // NOTE: the memory array has no reset; clearing it would prevent block-RAM
  // mapping, and the fill engine is the intended way to initialise it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Read stage 1 (RAM output).
  logic [PIX_W-1:0] rd1_q;
  logic             rv1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rv1_q <= re;
      if (re) begin
        // NOTE: non-blocking update samples mem before this edge's write,
        // which gives read-first behaviour on a same-address collision.
        rd1_q <= raddr_ok ? mem[raddr[IDX_W-1:0]] : '0;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    // Optional output register; data holds when no read is in flight.
    logic [PIX_W-1:0] rd2_q;
    logic             rv2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) begin
          rd2_q <= rd1_q;
        end
      end
    end

    assign rdata  = rd2_q;
    assign rvalid = rv2_q;
  end else begin : g_lat1
    assign rdata  = rd1_q;
    assign rvalid = rv1_q;
  end

endmodule
